// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive stage.
package ps2_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRecv
  } ps2_state_e;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned START      = 0;
  localparam int unsigned PAR        = 9;
  localparam int unsigned STOP       = 10;

endpackage

// File: rtl/ps2_scan_rx_if.sv
// PS/2 line inputs and scan-code outputs of the receive stage.
interface ps2_scan_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       ready;
  logic       frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  data,
    input  ready,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output data,
    output ready,
    output frame_err
  );
endinterface

// File: rtl/ps2_sync_filter.sv
// Synchroniser plus glitch filter for one asynchronous line; emits the filtered
// level and a one-cycle strobe on its 1->0 transition.
module ps2_sync_filter #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned FilterLen  = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int unsigned CntW = $clog2(FilterLen + 1);

  logic [SyncStages-1:0] sync_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  level_q, level_d;
  logic                  synced, flip;

  assign synced = sync_q[SyncStages-1];

  always_comb begin
    cnt_d = '0;
    flip  = 1'b0;
    // Count consecutive samples that disagree with the filtered level.
    if (synced != level_q) begin
      if (cnt_q == CntW'(FilterLen - 1)) begin
        flip = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    level_d = level_q ^ flip;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SyncStages-2:0], raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign fall  = flip & level_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, checks parity and stop,
// presents the scan code with a held ready strobe and flags bad frames.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned READY_HOLD     = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  ps2_scan_rx_if.slave  bus
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HoldW  = $clog2(READY_HOLD + 1);

  ps2_state_e             state_q, state_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic [7:0]             data_q, data_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic                   err_q, err_d;
  logic [SYNC_STAGES-1:0] dsync_q;
  logic                   clk_filt, clk_fall, sample, sbit;

  ps2_sync_filter #(
    .SyncStages (SYNC_STAGES),
    .FilterLen  (FILTER_LEN)
  ) u_clk_filter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .raw   (bus.ps2_clk),
    .level (clk_filt),
    .fall  (clk_fall)
  );

  assign sample = clk_fall & clk_filt;
  assign sbit   = dsync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    timer_d  = timer_q;
    data_d   = data_q;
    err_d    = 1'b0;
    hold_d   = (hold_q != '0) ? hold_q - 1'b1 : '0;
    unique case (state_q)
      StIdle: begin
        if (sample && !sbit) begin
          state_d  = StRecv;
          bitcnt_d = 4'd1;
          timer_d  = '0;
        end
      end
      StRecv: begin
        if (sample) begin
          timer_d  = '0;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q < 4'(PAR)) begin
            shift_d = {sbit, shift_q[7:1]};
          end else if (bitcnt_q == 4'(PAR)) begin
            par_d = sbit;
          end else begin
            state_d  = StIdle;
            bitcnt_d = '0;
            if ((^{shift_q, par_q}) && sbit) begin
              data_d = shift_q;
              hold_d = HoldW'(READY_HOLD);
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          state_d  = StIdle;
          bitcnt_d = '0;
          timer_d  = '0;
          err_d    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      timer_q  <= '0;
      data_q   <= '0;
      hold_q   <= '0;
      err_q    <= 1'b0;
      dsync_q  <= '1;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      timer_q  <= timer_d;
      data_q   <= data_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      dsync_q  <= {dsync_q[SYNC_STAGES-2:0], bus.ps2_data};
    end
  end

  assign bus.data      = data_q;
  assign bus.ready     = (hold_q != '0);
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: directed scenarios plus random frames against a
// frame-level model (odd parity, stop bit, last good code).
module tb_ps2_scan_rx;

  logic clk;
  logic rst;

  ps2_scan_rx_if bus ();
  ps2_scan_rx_if bus_l ();

  assign bus_l.ps2_clk  = bus.ps2_clk;
  assign bus_l.ps2_data = bus.ps2_data;

  ps2_scan_rx dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Long hold so a second frame can complete while ready is still high.
  ps2_scan_rx #(
    .READY_HOLD (1000)
  ) dut_long (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling clock edge.
  int   cyc = 0;
  int   rises = 0, run_len = 0, last_run = 0, errs = 0, err_cyc = 0, both = 0;
  int   l_rises = 0, l_run = 0, l_last_run = 0;
  logic rdy_prev = 1'b0, l_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ready) begin
      if (!rdy_prev) begin
        rises   <= rises + 1;
        run_len <= 1;
      end else begin
        run_len <= run_len + 1;
      end
    end else if (rdy_prev) begin
      last_run <= run_len;
    end
    rdy_prev <= bus.ready;
    if (bus.frame_err) begin
      errs    <= errs + 1;
      err_cyc <= cyc;
    end
    if (bus.frame_err && bus.ready) both <= both + 1;
    if (bus_l.ready) begin
      if (!l_prev) begin
        l_rises <= l_rises + 1;
        l_run   <= 1;
      end else begin
        l_run <= l_run + 1;
      end
    end else if (l_prev) begin
      l_last_run <= l_run;
    end
    l_prev <= bus_l.ready;
  end

  logic [7:0] exp_data;
  int         last_fall;

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic par,
                                           input logic stop);
    return {stop, par, code, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = frame[i];
      repeat (half) @(negedge clk);
      bus.ps2_clk = 1'b0;
      last_fall   = cyc;
      repeat (half) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] code, input logic par, input logic stop,
                           input int half, input string tag);
    logic ok;
    int   r0, e0;
    ok = stop && ((^code) ^ par);
    r0 = rises;
    e0 = errs;
    send_bits(mk_frame(code, par, stop), 11, half);
    repeat (20) @(negedge clk);
    check_eq({tag, "_ready_rises"}, rises - r0, {31'd0, ok});
    check_eq({tag, "_frame_errs"}, errs - e0, {31'd0, !ok});
    if (ok) begin
      check_eq({tag, "_ready_len"}, last_run, 4);
      exp_data = code;
    end
    check_eq({tag, "_data"}, {24'd0, bus.data}, {24'd0, exp_data});
  endtask

  initial begin
    int e0, r0, lr0;
    logic [7:0] code;
    logic       par, stop;
    int         kind, half;

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst          = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_data", {24'd0, bus.data}, 0);
    check_eq("rst_ready", {31'd0, bus.ready}, 0);
    check_eq("rst_frame_err", {31'd0, bus.frame_err}, 0);
    check_eq("rst_long_ready", {31'd0, bus_l.ready}, 0);
    exp_data = 8'h00;

    run_frame(8'h1C, 1'b0, 1'b1, 60, "t1_good");
    run_frame(8'h1C, 1'b1, 1'b1, 60, "t2_badpar");

    // Short low glitch on ps2_clk with data low must not start a frame.
    e0 = errs;
    r0 = rises;
    bus.ps2_data = 1'b0;
    @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("t4_glitch_err", errs - e0, 0);
    check_eq("t4_glitch_ready", rises - r0, 0);
    run_frame(8'h33, 1'b1, 1'b1, 40, "t4_after");

    // Reset in the middle of a frame.
    e0 = errs;
    send_bits(mk_frame(8'h77, 1'b0, 1'b1), 5, 40);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_data", {24'd0, bus.data}, 0);
    check_eq("t5_ready", {31'd0, bus.ready}, 0);
    repeat (100) @(negedge clk);
    check_eq("t5_no_err", errs - e0, 0);
    exp_data = 8'h00;
    run_frame(8'h5A, 1'b1, 1'b1, 40, "t5_after");

    // Partial frame then idle line: abort after the timeout.
    e0 = errs;
    send_bits(mk_frame(8'hAA, 1'b1, 1'b1), 5, 40);
    repeat (50100) @(negedge clk);
    check_eq("t3_timeout_err", errs - e0, 1);
    check_eq("t3_timeout_when", {31'd0, (err_cyc - last_fall >= 49995) &&
                                        (err_cyc - last_fall <= 50020)}, 1);
    check_eq("t3_data_kept", {24'd0, bus.data}, {24'd0, exp_data});
    run_frame(8'hF0, 1'b1, 1'b1, 40, "t3_after");

    // Back-to-back frames; the second lands inside the long ready hold.
    repeat (1100) @(negedge clk);
    lr0 = l_rises;
    e0  = errs;
    run_frame(8'hF0, 1'b1, 1'b1, 20, "t6_first");
    check_eq("t6_long_data1", {24'd0, bus_l.data}, 32'hF0);
    run_frame(8'h1C, 1'b0, 1'b1, 20, "t6_second");
    check_eq("t6_long_data2", {24'd0, bus_l.data}, 32'h1C);
    check_eq("t6_long_ready", {31'd0, bus_l.ready}, 1);
    repeat (1600) @(negedge clk);
    check_eq("t6_long_rises", l_rises - lr0, 1);
    check_eq("t6_hold_reload", {31'd0, l_last_run > 1200}, 1);
    check_eq("t6_no_err", errs - e0, 0);

    // Random frames, some with corrupted parity or stop bit.
    for (int n = 0; n < 10; n++) begin
      code = 8'($urandom);
      kind = $urandom_range(0, 3);
      half = $urandom_range(25, 60);
      par  = ~^code;
      stop = 1'b1;
      if (kind == 2) par = ~par;
      if (kind == 3) stop = 1'b0;
      run_frame(code, par, stop, half, $sformatf("rnd%0d", n));
    end

    check_eq("err_ready_overlap", both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
